lfsr_stream: RTL and testbench

//  Parametrised pseudo-random bit source: one LFSR of configurable width and

---
 rtl/lfsr_pkg.sv | 34 +++
 rtl/lfsr_stream_if.sv | 11 +
 rtl/lfsr_stream.sv | 96 +++++++++
 tb/tb_lfsr_stream.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR constants and the single-shift function used by the stream source.
// Vectors are carried at the maximum supported width; callers zero-extend and truncate.
package lfsr_pkg;

    localparam int MODE_FIB    = 0;
    localparam int MODE_GALOIS = 1;
    localparam int MAX_W       = 256;

    localparam logic [194:0] LFSR_TAPS_195 = (195'd1 << 194) | (195'd1 << 192)
                                           | (195'd1 << 191) | (195'd1 << 186);

    // One shift of a width-bit LFSR; bits at and above width stay zero.
    function automatic logic [MAX_W-1:0] lfsr_next(
        input logic [MAX_W-1:0] cur,
        input logic [MAX_W-1:0] taps,
        input int               width,
        input int               mode
    );
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] shifted;
        logic [MAX_W-1:0] nxt;
        logic             msb;
        mask    = {MAX_W{1'b1}} >> (MAX_W - width);
        shifted = (cur << 1) & mask;
        msb     = cur[8'(width - 1)];
        if (mode == MODE_GALOIS) begin
            nxt = shifted ^ ({MAX_W{msb}} & taps);
        end else begin
            nxt = shifted | MAX_W'(^(cur & taps));
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lfsr_stream_if.sv
// Valid/ready word stream carrying LFSR output words of DW bits.
interface lfsr_stream_if #(
    parameter int DW = 1
) ();
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/lfsr_stream.sv
// Parametrised Fibonacci/Galois LFSR advancing STEP shifts per accepted word,
// with runtime seed load and a sticky flag for zero-seed replacement.
module lfsr_stream
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 195,
    parameter int               MODE  = MODE_FIB,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS_195),
    parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}},
    parameter int               STEP  = 1,
    parameter int               CNT_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              seed_load,
    input  logic [WIDTH-1:0]  seed_data,
    lfsr_stream_if.master     out_if,
    output logic [WIDTH-1:0]  state,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              lockup
);

    if (WIDTH < 2 || WIDTH > MAX_W) begin : g_bad_width
        $error("lfsr_stream: WIDTH must be 2..256");
    end
    if (STEP < 1 || STEP > WIDTH) begin : g_bad_step
        $error("lfsr_stream: STEP must be 1..WIDTH");
    end
    if (TAPS == '0) begin : g_zero_taps
        $error("lfsr_stream: TAPS must be nonzero");
    end
    if (MODE == MODE_GALOIS && !TAPS[0]) begin : g_galois_bit0
        $error("lfsr_stream: Galois TAPS needs bit 0 set");
    end

    logic [WIDTH-1:0] state_q, state_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lockup_q, lockup_d;
    logic             fire;

    // STEP single shifts chained combinationally; chain[STEP] is the post-fire state.
    logic [STEP:0][WIDTH-1:0] chain;
    assign chain[0] = state_q;

    for (genvar gi = 0; gi < STEP; gi++) begin : g_unroll
        assign chain[gi+1] = WIDTH'(lfsr_next(MAX_W'(chain[gi]), MAX_W'(TAPS), WIDTH, MODE));
    end

    assign fire = valid_q & out_if.ready;

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        lockup_d = lockup_q;
        if (seed_load) begin
            // A zero seed would freeze the register, so fall back to SEED and flag it.
            if (seed_data == '0) begin
                state_d  = SEED;
                lockup_d = 1'b1;
            end else begin
                state_d  = seed_data;
            end
            cnt_d   = '0;
            valid_d = 1'b0;
        end else begin
            valid_d = 1'b1;
            if (fire) begin
                state_d = chain[STEP];
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= SEED;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
            lockup_q <= lockup_d;
        end
    end

    assign out_if.valid = valid_q;
    assign out_if.data  = state_q[STEP-1:0];
    assign state        = state_q;
    assign word_cnt     = cnt_q;
    assign lockup       = lockup_q;

endmodule

// File: tb/tb_lfsr_stream.sv
// Self-checking bench for lfsr_stream: four configurations side by side, checked
// against a bit-stream / GF(2) polynomial reference model.
module tb_lfsr_stream;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT 0: W4 Fibonacci, 1: W4 Galois, 2: W4 Fibonacci STEP=4, 3: default 195-bit
    logic         rdy   [4];
    logic         sload [4];
    logic [255:0] sdata [4];

    int           p_w    [4] = '{4, 4, 4, 195};
    int           p_mode [4] = '{0, 1, 0, 0};
    int           p_step [4] = '{1, 1, 4, 1};
    logic [255:0] p_taps [4];
    logic [255:0] p_seed [4];

    logic [255:0] m_state [4];
    logic         m_valid [4];
    logic [31:0]  m_cnt   [4];
    logic         m_lock  [4];

    logic [3:0]   st0, st1, st2;
    logic [194:0] st3;
    logic [31:0]  cnt0, cnt1, cnt2, cnt3;
    logic         lk0, lk1, lk2, lk3;

    lfsr_stream_if #(.DW(1)) if0 ();
    lfsr_stream_if #(.DW(1)) if1 ();
    lfsr_stream_if #(.DW(4)) if2 ();
    lfsr_stream_if #(.DW(1)) if3 ();

    assign if0.ready = rdy[0];
    assign if1.ready = rdy[1];
    assign if2.ready = rdy[2];
    assign if3.ready = rdy[3];

    lfsr_stream #(.WIDTH(4), .MODE(0), .TAPS(4'b1001), .SEED(4'b0001), .STEP(1), .CNT_W(32)) u_fib (
        .clk(clk), .rstn(rstn), .seed_load(sload[0]), .seed_data(sdata[0][3:0]),
        .out_if(if0), .state(st0), .word_cnt(cnt0), .lockup(lk0));
    lfsr_stream #(.WIDTH(4), .MODE(1), .TAPS(4'b0011), .SEED(4'b0001), .STEP(1), .CNT_W(32)) u_gal (
        .clk(clk), .rstn(rstn), .seed_load(sload[1]), .seed_data(sdata[1][3:0]),
        .out_if(if1), .state(st1), .word_cnt(cnt1), .lockup(lk1));
    lfsr_stream #(.WIDTH(4), .MODE(0), .TAPS(4'b1001), .SEED(4'b0001), .STEP(4), .CNT_W(32)) u_st4 (
        .clk(clk), .rstn(rstn), .seed_load(sload[2]), .seed_data(sdata[2][3:0]),
        .out_if(if2), .state(st2), .word_cnt(cnt2), .lockup(lk2));
    lfsr_stream u_def (
        .clk(clk), .rstn(rstn), .seed_load(sload[3]), .seed_data(sdata[3][194:0]),
        .out_if(if3), .state(st3), .word_cnt(cnt3), .lockup(lk3));

    logic [255:0] o_state [4];
    logic [255:0] o_data  [4];
    logic         o_valid [4];
    logic [31:0]  o_cnt   [4];
    logic         o_lock  [4];

    assign o_state[0] = 256'(st0);
    assign o_state[1] = 256'(st1);
    assign o_state[2] = 256'(st2);
    assign o_state[3] = 256'(st3);
    assign o_data[0]  = 256'(if0.data);
    assign o_data[1]  = 256'(if1.data);
    assign o_data[2]  = 256'(if2.data);
    assign o_data[3]  = 256'(if3.data);
    assign o_valid[0] = if0.valid;
    assign o_valid[1] = if1.valid;
    assign o_valid[2] = if2.valid;
    assign o_valid[3] = if3.valid;
    assign o_cnt[0] = cnt0;
    assign o_cnt[1] = cnt1;
    assign o_cnt[2] = cnt2;
    assign o_cnt[3] = cnt3;
    assign o_lock[0] = lk0;
    assign o_lock[1] = lk1;
    assign o_lock[2] = lk2;
    assign o_lock[3] = lk3;

    function automatic logic [255:0] wmask(input int w);
        return {256{1'b1}} >> (256 - w);
    endfunction

    // Fibonacci: state is a sliding window over the output bit stream; the new bit is
    // the parity of the tapped window bits. Galois: state is a polynomial, multiplied by x mod P.
    function automatic logic [255:0] model_advance(input int d, input logic [255:0] s);
        int           ones;
        logic [256:0] t;
        if (p_mode[d] == 0) begin
            ones = $countones(s & p_taps[d]);
            return ((s << 1) | 256'(ones % 2)) & wmask(p_w[d]);
        end
        t = {s, 1'b0};
        if (t[p_w[d]]) t = t ^ ((257'd1 << p_w[d]) | {1'b0, p_taps[d]});
        return t[255:0];
    endfunction

    // Advance one clock: update the model from the inputs currently driven, then step the DUTs.
    task automatic tick();
        logic [255:0] ns [4];
        logic         nv [4];
        logic [31:0]  nc [4];
        logic         nl [4];
        for (int d = 0; d < 4; d++) begin
            ns[d] = m_state[d]; nv[d] = m_valid[d]; nc[d] = m_cnt[d]; nl[d] = m_lock[d];
            if (!rstn) begin
                ns[d] = p_seed[d]; nv[d] = 1'b0; nc[d] = 0; nl[d] = 1'b0;
            end else if (sload[d]) begin
                ns[d] = (sdata[d] == 0) ? p_seed[d] : sdata[d];
                if (sdata[d] == 0) nl[d] = 1'b1;
                nc[d] = 0; nv[d] = 1'b0;
            end else begin
                nv[d] = 1'b1;
                if (m_valid[d] && rdy[d]) begin
                    for (int k = 0; k < p_step[d]; k++) ns[d] = model_advance(d, ns[d]);
                    nc[d] = m_cnt[d] + 1;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            m_state[d] = ns[d]; m_valid[d] = nv[d]; m_cnt[d] = nc[d]; m_lock[d] = nl[d];
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (o_state[d] !== p_seed[d] || o_valid[d] !== 1'b0 || o_cnt[d] !== 32'd0 || o_lock[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset dut%0d: state=%h valid=%b cnt=%0d lock=%b, expected state=%h valid=0 cnt=0 lock=0",
                         d, o_state[d], o_valid[d], o_cnt[d], o_lock[d], p_seed[d]);
            end
        end
        rstn = 1'b1;
        tick();
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (o_valid[d] !== 1'b1) begin
                errors++;
                $display("FAIL valid_after_reset dut%0d: valid=%b expected 1", d, o_valid[d]);
            end
        end
    endtask

    task automatic test_fib_sequence();
        logic [3:0] exp_seq [5] = '{4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1101};
        rdy[0] = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (i < 5) begin
                checks++;
                if (st0 !== exp_seq[i]) begin
                    errors++;
                    $display("FAIL fib_seq step%0d: state=%b expected %b", i, st0, exp_seq[i]);
                end
            end
            checks++;
            if (o_state[0] !== m_state[0] || o_data[0] !== (m_state[0] & 256'd1)) begin
                errors++;
                $display("FAIL fib_model step%0d: state=%h data=%h expected state=%h", i, o_state[0], o_data[0], m_state[0]);
            end
        end
        rdy[0] = 1'b0;
        checks++;
        if (st0 !== 4'b0001 || cnt0 !== 32'd15) begin
            errors++;
            $display("FAIL fib_period: state=%b cnt=%0d expected state=0001 cnt=15", st0, cnt0);
        end
    endtask

    task automatic test_galois_period();
        logic [3:0] exp_seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0011};
        int first_return = -1;
        rdy[1] = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (i < 4) begin
                checks++;
                if (st1 !== exp_seq[i]) begin
                    errors++;
                    $display("FAIL galois_seq step%0d: state=%b expected %b", i, st1, exp_seq[i]);
                end
            end
            if (st1 === 4'b0001 && first_return < 0) first_return = i + 1;
        end
        rdy[1] = 1'b0;
        checks++;
        if (first_return !== 15 || cnt1 !== 32'd15 || o_state[1] !== m_state[1]) begin
            errors++;
            $display("FAIL galois_period: first return after %0d fires cnt=%0d state=%b, expected 15 fires cnt=15 state=%h",
                     first_return, cnt1, st1, m_state[1]);
        end
    endtask

    task automatic test_step4();
        rdy[2] = 1'b1;
        tick();
        rdy[2] = 1'b0;
        checks++;
        if (st2 !== 4'b1110 || if2.data !== 4'b1110 || cnt2 !== 32'd1) begin
            errors++;
            $display("FAIL step4_fire: state=%b data=%b cnt=%0d expected state=1110 data=1110 cnt=1", st2, if2.data, cnt2);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0]  held_state;
        logic [31:0] held_cnt;
        rdy[0] = 1'b1;
        tick();
        tick();
        rdy[0] = 1'b0;
        tick();
        held_state = m_state[0][3:0];
        held_cnt   = m_cnt[0];
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (st0 !== held_state || if0.data !== held_state[0] || cnt0 !== held_cnt || if0.valid !== 1'b1) begin
                errors++;
                $display("FAIL backpressure cyc%0d: state=%b data=%b cnt=%0d valid=%b expected state=%b cnt=%0d valid=1",
                         i, st0, if0.data, cnt0, if0.valid, held_state, held_cnt);
            end
        end
    endtask

    task automatic test_zero_seed();
        sload[0] = 1'b1;
        sdata[0] = '0;
        rdy[0]   = 1'b1;
        tick();
        sload[0] = 1'b0;
        checks++;
        if (st0 !== 4'b0001 || lk0 !== 1'b1 || if0.valid !== 1'b0 || cnt0 !== 32'd0) begin
            errors++;
            $display("FAIL zero_seed: state=%b lock=%b valid=%b cnt=%0d expected state=0001 lock=1 valid=0 cnt=0",
                     st0, lk0, if0.valid, cnt0);
        end
        tick();
        rdy[0] = 1'b0;
        checks++;
        if (if0.valid !== 1'b1 || st0 !== 4'b0001 || lk0 !== 1'b1) begin
            errors++;
            $display("FAIL zero_seed_after: valid=%b state=%b lock=%b expected valid=1 state=0001 lock=1", if0.valid, st0, lk0);
        end
    endtask

    task automatic test_load_priority();
        sload[1] = 1'b1;
        sdata[1] = 256'hA;
        rdy[1]   = 1'b1;
        tick();
        sload[1] = 1'b0;
        rdy[1]   = 1'b0;
        checks++;
        if (st1 !== 4'b1010 || cnt1 !== 32'd0 || if1.valid !== 1'b0 || lk1 !== 1'b0) begin
            errors++;
            $display("FAIL load_priority: state=%b cnt=%0d valid=%b lock=%b expected state=1010 cnt=0 valid=0 lock=0",
                     st1, cnt1, if1.valid, lk1);
        end
    endtask

    task automatic test_random_stream();
        logic [255:0] r;
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 4; d++) begin
                rdy[d]   = ($urandom_range(3) != 0);
                sload[d] = ($urandom_range(19) == 0);
                r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                r = r & wmask(p_w[d]);
                if ($urandom_range(3) == 0) r = '0;
                sdata[d] = r;
            end
            tick();
            for (int d = 0; d < 4; d++) begin
                checks++;
                if (o_state[d] !== m_state[d] || o_valid[d] !== m_valid[d] || o_cnt[d] !== m_cnt[d]
                    || o_lock[d] !== m_lock[d] || o_data[d] !== (m_state[d] & wmask(p_step[d]))) begin
                    errors++;
                    $display("FAIL random dut%0d cyc%0d: state=%h valid=%b cnt=%0d lock=%b data=%h expected state=%h valid=%b cnt=%0d lock=%b",
                             d, c, o_state[d], o_valid[d], o_cnt[d], o_lock[d], o_data[d],
                             m_state[d], m_valid[d], m_cnt[d], m_lock[d]);
                end
            end
        end
        for (int d = 0; d < 4; d++) begin
            sload[d] = 1'b0;
            rdy[d]   = 1'b0;
        end
    endtask

    task automatic test_midstream_reset();
        for (int d = 0; d < 4; d++) rdy[d] = 1'b1;
        tick();
        tick();
        rstn = 1'b0;
        tick();
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (o_state[d] !== p_seed[d] || o_valid[d] !== 1'b0 || o_cnt[d] !== 32'd0 || o_lock[d] !== 1'b0) begin
                errors++;
                $display("FAIL midstream_reset dut%0d: state=%h valid=%b cnt=%0d lock=%b expected state=%h valid=0 cnt=0 lock=0",
                         d, o_state[d], o_valid[d], o_cnt[d], o_lock[d], p_seed[d]);
            end
        end
        rstn = 1'b1;
        tick();
        for (int d = 0; d < 4; d++) rdy[d] = 1'b0;
    endtask

    initial begin
        p_taps[0] = 256'h9;
        p_taps[1] = 256'h3;
        p_taps[2] = 256'h9;
        p_taps[3] = (256'd1 << 194) | (256'd1 << 192) | (256'd1 << 191) | (256'd1 << 186);
        p_seed[0] = 256'h1;
        p_seed[1] = 256'h1;
        p_seed[2] = 256'h1;
        p_seed[3] = wmask(195);
        for (int d = 0; d < 4; d++) begin
            rdy[d] = 1'b0; sload[d] = 1'b0; sdata[d] = '0;
            m_state[d] = '0; m_valid[d] = 1'b0; m_cnt[d] = 0; m_lock[d] = 1'b0;
        end

        test_reset();
        test_fib_sequence();
        test_galois_period();
        test_step4();
        test_backpressure();
        test_zero_seed();
        test_load_priority();
        test_random_stream();
        test_midstream_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
